speed_tick_divider: RTL

//  Parametrised, run-time speed-selectable clock-enable generator for the Morse decoder timebase.

---
 rtl/morse_timing_pkg.sv | 18 +
 rtl/div_period_calc.sv | 23 ++
 rtl/speed_tick_divider.sv | 81 ++++++++
 3 files changed

// File: rtl/morse_timing_pkg.sv
// rtl/morse_timing_pkg.sv - shared timing constants and saturating period helper
package morse_timing_pkg;

    localparam int DEF_CNT_W   = 28;
    localparam int DEF_SEL_W   = 3;
    localparam int SPD_FASTEST = 0;
    localparam int SPD_SLOWEST = 2**DEF_SEL_W - 1;

    // Adds at one bit wider than the operands so the carry is seen, then clamps to lim.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] lim);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sat_add = (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/div_period_calc.sv
// rtl/div_period_calc.sv - combinational speed index to terminal count, saturating
module div_period_calc
    import morse_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int BASE_DIV = 2,
    parameter int STEP_DIV = 1
) (
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] period
);

    localparam logic [63:0] LIM = (64'd1 << CNT_W) - 64'd1;

    logic [63:0] step;

    always_comb begin
        step   = 64'(sel) * 64'(STEP_DIV);
        period = CNT_W'(sat_add(64'(BASE_DIV), step, LIM));
    end

endmodule

// File: rtl/speed_tick_divider.sv
// rtl/speed_tick_divider.sv - speed-selectable tick/toggle timebase with boundary-aligned speed changes
module speed_tick_divider
    import morse_timing_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int BASE_DIV = 2,
    parameter int STEP_DIV = 1,
    parameter int RST_SEL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [SEL_W-1:0] sel,
    output logic             tick,
    output logic             out,
    output logic             upd,
    output logic [SEL_W-1:0] cur_sel
);

    localparam logic [CNT_W-1:0] RST_T =
        CNT_W'(sat_add(64'(BASE_DIV), 64'(RST_SEL) * 64'(STEP_DIV), (64'd1 << CNT_W) - 64'd1));

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] term;
    logic [SEL_W-1:0] pend;
    logic [CNT_W-1:0] t_pend;
    logic [CNT_W-1:0] t_sel;

    // One calculator serves the boundary reload, the other the immediate load on clear.
    div_period_calc #(
        .CNT_W(CNT_W), .SEL_W(SEL_W), .BASE_DIV(BASE_DIV), .STEP_DIV(STEP_DIV)
    ) u_calc_pend (
        .sel(pend), .period(t_pend)
    );

    div_period_calc #(
        .CNT_W(CNT_W), .SEL_W(SEL_W), .BASE_DIV(BASE_DIV), .STEP_DIV(STEP_DIV)
    ) u_calc_sel (
        .sel(sel), .period(t_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            term    <= RST_T;
            pend    <= SEL_W'(RST_SEL);
            cur_sel <= SEL_W'(RST_SEL);
            tick    <= 1'b0;
            out     <= 1'b0;
            upd     <= 1'b0;
        end else begin
            pend <= sel;
            tick <= 1'b0;
            upd  <= 1'b0;
            if (sync_clr) begin
                count   <= '0;
                out     <= 1'b0;
                cur_sel <= sel;
                term    <= t_sel;
                upd     <= (sel != cur_sel);
            end else if (en) begin
                if (count == term) begin
                    count <= '0;
                    tick  <= 1'b1;
                    out   <= ~out;
                    // Speed changes only land here, so no period is ever cut short.
                    if (pend != cur_sel) begin
                        cur_sel <= pend;
                        term    <= t_pend;
                        upd     <= 1'b1;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule
